// File: rtl/operand_entry.sv
// Operand entry front end: synchronised switches, debounced ENTER,
// sign-magnitude to two's complement, one valid/ready packet per press.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       ar,
  input  logic       aSign,
  input  logic [2:0] a_mag,
  input  logic       bSign,
  input  logic [2:0] b_mag,
  input  logic       switchAdd,
  input  logic       switchSub,
  input  logic       enter,
  output logic [3:0] a_op,
  output logic [3:0] b_op,
  output logic [1:0] mode,
  output logic       op_valid,
  input  logic       op_ready,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, CAPTURE, HOLD, RELEASE
  } state_e;

  state_e state_q, state_d;

  logic [10:0]   sync_q [SYNC_STAGES];
  logic [10:0]   sync_d [SYNC_STAGES];
  logic [10:0]   s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic [3:0]    a_op_q, a_op_d;
  logic [3:0]    b_op_q, b_op_d;
  logic [1:0]    mode_q, mode_d;
  logic          op_valid_q, op_valid_d;
  logic          err_q, err_d;
  logic          en_s, sel_ok;
  logic [1:0]    sel_mode;

  function automatic logic [3:0] to_tc(
    input logic       sgn,
    input logic [2:0] mag
  );
    // -0 wraps to 0000 naturally, so 1000 can never appear
    to_tc = sgn ? 4'(4'd0 - {1'b0, mag}) : {1'b0, mag};
  endfunction

  always_comb begin
    sync_d[0] = {enter, switchSub, switchAdd,
                 bSign, b_mag, aSign, a_mag};
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign en_s = s[10];

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (en_s != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = en_s;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    sel_ok   = s[8] | s[9];
    sel_mode = s[8] ? 2'b00 : 2'b01;
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      state_q    <= IDLE;
      a_op_q     <= '0;
      b_op_q     <= '0;
      mode_q     <= '0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      state_q    <= state_d;
      a_op_q     <= a_op_d;
      b_op_q     <= b_op_d;
      mode_q     <= mode_d;
      op_valid_q <= op_valid_d;
      err_q      <= err_d;
    end
  end

  // IDLE is only entered with deb_q low, so a high level there is a press
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (deb_q) state_d = sel_ok ? CAPTURE : RELEASE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (op_valid_q && op_ready) state_d = RELEASE;
      RELEASE: if (!deb_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_op_d     = a_op_q;
    b_op_d     = b_op_q;
    mode_d     = mode_q;
    op_valid_d = op_valid_q;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE:    err_d = deb_q & ~sel_ok;
      CAPTURE: begin
        a_op_d     = to_tc(s[3], s[2:0]);
        b_op_d     = to_tc(s[7], s[6:4]);
        mode_d     = sel_mode;
        op_valid_d = 1'b1;
      end
      HOLD:    if (op_ready) op_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign a_op     = a_op_q;
  assign b_op     = b_op_q;
  assign mode     = mode_q;
  assign op_valid = op_valid_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: presses queue expected packets,
// a negedge monitor pops and compares on every accepted handshake.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       ar;
  logic       aSign, bSign;
  logic [2:0] a_mag, b_mag;
  logic       switchAdd, switchSub;
  logic       enter;
  logic [3:0] a_op, b_op;
  logic [1:0] mode;
  logic       op_valid, op_ready;
  logic       busy, err;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] m;
  } pkt_t;

  pkt_t q[$];
  int   vecs = 0;
  int   mis  = 0;
  int   pkts = 0;
  int   errs = 0;
  int   vcyc = 0;
  logic [3:0] last_a = '0;

  operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .ar(ar),
    .aSign(aSign), .a_mag(a_mag),
    .bSign(bSign), .b_mag(b_mag),
    .switchAdd(switchAdd), .switchSub(switchSub),
    .enter(enter),
    .a_op(a_op), .b_op(b_op), .mode(mode),
    .op_valid(op_valid), .op_ready(op_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: signed value from sign/magnitude, then 4-bit wrap
  function automatic logic [3:0] tc(input logic sg,
                                    input logic [2:0] mg);
    int v;
    v = sg ? -int'(mg) : int'(mg);
    return v[3:0];
  endfunction

  always @(negedge clk) begin
    if (ar) begin
      if (op_valid) vcyc++;
      if (err) errs++;
      if (op_valid && op_ready) begin
        pkts++;
        if (q.size() == 0) begin
          chk("unexpected_pkt", 1, 0);
        end else begin
          pkt_t e;
          e = q.pop_front();
          chk("a_op", a_op, e.a);
          chk("b_op", b_op, e.b);
          chk("mode", mode, e.m);
        end
      end
    end
  end

  task automatic tick(inout int d);
    @(posedge clk); #1;
    if (op_valid && !op_ready) begin
      if (d == 0) op_ready = 1'b1;
      else d--;
    end
  endtask

  task automatic do_press(input logic sa, input logic [2:0] ma,
                          input logic sb, input logic [2:0] mb,
                          input logic ad, input logic su,
                          input int hold, input int rdelay,
                          input bit bounce);
    int p0, e0, v0, d;
    bit has;
    pkt_t e;
    aSign = sa; a_mag = ma; bSign = sb; b_mag = mb;
    switchAdd = ad; switchSub = su;
    has = ad | su;
    e.a = tc(sa, ma);
    e.b = tc(sb, mb);
    e.m = ad ? 2'b00 : 2'b01;
    if (has) q.push_back(e);
    d = rdelay;
    op_ready = (rdelay == 0);
    p0 = pkts; e0 = errs; v0 = vcyc;
    if (bounce) begin
      for (int i = 0; i < 20; i++) begin
        enter = ((i / 2) % 2 == 0);
        @(posedge clk); #1;
      end
      chk("bounce_nopkt", pkts, p0);
      chk("bounce_idle", busy, 0);
    end
    enter = 1'b1;
    for (int i = 0; i < hold; i++) tick(d);
    enter = 1'b0;
    for (int i = 0; i < 300 && busy; i++) tick(d);
    chk("back_to_idle", busy, 0);
    chk("pkt_count", pkts - p0, has ? 1 : 0);
    chk("err_count", errs - e0, has ? 0 : 1);
    chk("valid_cycles", vcyc - v0, has ? rdelay + 1 : 0);
    if (has) last_a = e.a;
    chk("a_op_retained", a_op, last_a);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !op_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("valid_seen", op_valid, 1);
  endtask

  initial begin
    pkt_t e;
    ar = 1'b0; enter = 1'b0; op_ready = 1'b0;
    aSign = 1'b0; a_mag = 3'd0; bSign = 1'b0; b_mag = 3'd0;
    switchAdd = 1'b0; switchSub = 1'b0;
    #23;
    chk("rst_a_op", a_op, 0);
    chk("rst_b_op", b_op, 0);
    chk("rst_mode", mode, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1; ar = 1'b1;
    repeat (3) @(posedge clk); #1;

    do_press(0, 3'd3, 1, 3'd5, 1, 0, 20, 0, 0);
    do_press(0, 3'd6, 1, 3'd1, 0, 1, 12, 0, 1);
    do_press(1, 3'd4, 0, 3'd2, 0, 0, 12, 0, 0);
    do_press(1, 3'd0, 0, 3'd2, 1, 0, 12, 0, 0);
    do_press(1, 3'd7, 1, 3'd7, 1, 1, 12, 1, 0);

    // frozen packet while the sink stalls
    aSign = 0; a_mag = 3'd2; bSign = 1; b_mag = 3'd3;
    switchAdd = 0; switchSub = 1; op_ready = 0;
    e.a = tc(0, 3'd2); e.b = tc(1, 3'd3); e.m = 2'b01;
    q.push_back(e);
    enter = 1'b1;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      a_mag = 3'($urandom_range(0, 7));
      switchSub = i[0];
      switchAdd = ~i[0];
      @(posedge clk); #1;
      chk("hold_valid", op_valid, 1);
      chk("hold_a_op", a_op, e.a);
      chk("hold_mode", mode, 2'b01);
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("valid_drop", op_valid, 0);
    last_a = e.a;
    enter = 1'b0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("stall_idle", busy, 0);

    // reset in HOLD drops the packet
    aSign = 1; a_mag = 3'd6; bSign = 0; b_mag = 3'd1;
    switchAdd = 1; switchSub = 0; op_ready = 0;
    e.a = tc(1, 3'd6); e.b = tc(0, 3'd1); e.m = 2'b00;
    q.push_back(e);
    enter = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    ar = 1'b0; enter = 1'b0;
    #1;
    chk("mid_rst_a_op", a_op, 0);
    chk("mid_rst_b_op", b_op, 0);
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_valid", op_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    q.delete();
    last_a = '0;
    begin
      int p0;
      p0 = pkts;
      @(posedge clk); #1; ar = 1'b1; op_ready = 1'b1;
      repeat (20) @(posedge clk); #1;
      chk("post_rst_nopkt", pkts, p0);
      chk("post_rst_idle", busy, 0);
    end

    for (int n = 0; n < 20; n++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      do_press(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
               sel[0], sel[1], $urandom_range(10, 20),
               $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
    end

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, mis);
    $finish;
  end

endmodule
